gf_mul_seq: RTL and testbench

GF_MUL_SEQ -- requirements
Module: gf_mul_seq

---
 rtl/gf_mul_seq.sv | 195 +++++++++++++++++++
 tb/tb_gf_mul_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mul_seq.sv
// Sequential integer / carry-less multiplier with optional reduction by a primitive polynomial.
// The reduction stage is compiled only when GF_MUL_SEQ_REDUCE_EN is defined.
module gf_mul_seq #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        carry_option,
    input  logic                        red_funct,
    input  logic [$clog2(DATA_WIDTH):0] polyn_grade,
    input  logic [DATA_WIDTH:0]         polyn_red_in,
    input  logic [DATA_WIDTH-1:0]       a,
    input  logic [DATA_WIDTH-1:0]       b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*DATA_WIDTH-1:0]     mult_out,
    output logic [DATA_WIDTH-1:0]       out_poly,
    output logic                        busy
);

    localparam int W     = DATA_WIDTH;
    localparam int B     = BITS_PER_CYCLE;
    localparam int STEPS = W / B;
    localparam int CW    = $clog2(STEPS + 1);

`ifdef GF_MUL_SEQ_REDUCE_EN
    typedef enum logic [1:0] {IDLE, MULT, REDUCE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
`endif

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            mult_last;
    logic            mult_to_done;
    logic            reduce_to_done;
    logic [2*W-1:0]  a_sh;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  acc_step;
    logic [W-1:0]    b_sh;
    logic [CW-1:0]   cnt;
    logic            carry_mode;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign mult_last = (state == MULT) && (cnt == '0);

    always_comb begin : mult_step
        // NOTE: blocking assignments chain the B partial products through one cycle.
        acc_step = acc;
        for (int j = 0; j < B; j++) begin
            if (b_sh[j]) begin
                acc_step = carry_mode ? (acc_step + (a_sh << j)) : (acc_step ^ (a_sh << j));
            end
        end
    end

`ifdef GF_MUL_SEQ_REDUCE_EN
    localparam int MW = $clog2(W) + 1;
    localparam int KW = $clog2(2 * W);

    logic            red_req;
    logic            red_en;
    logic            red_last;
    logic [MW-1:0]   m_reg;
    logic [W:0]      poly_reg;
    logic [2*W-1:0]  rem;
    logic [2*W-1:0]  rem_step;
    logic [2*W-1:0]  poly_sh;
    logic [KW-1:0]   k;
    logic [KW-1:0]   shamt;
    logic [W-1:0]    mask;
    logic [W-1:0]    out_poly_q;

    // Degrees outside 2..W cannot be reduced meaningfully, so the scan is skipped.
    assign red_req        = red_funct && (polyn_grade >= MW'(2)) && (polyn_grade <= MW'(W));
    assign red_last       = (state == REDUCE) && (k == KW'(m_reg));
    assign mult_to_done   = mult_last && !red_en;
    assign reduce_to_done = red_last;
    assign busy           = (state == MULT) || (state == REDUCE);
    assign out_poly       = out_poly_q;

    always_comb begin : reduce_step
        shamt    = k - KW'(m_reg);
        poly_sh  = {{(W-1){1'b0}}, poly_reg} << shamt;
        rem_step = rem[k] ? (rem ^ poly_sh) : rem;
        mask     = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (i < int'(m_reg));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_en     <= 1'b0;
            m_reg      <= '0;
            poly_reg   <= '0;
            rem        <= '0;
            k          <= '0;
            out_poly_q <= '0;
        end else if (accept) begin
            red_en   <= red_req;
            m_reg    <= polyn_grade;
            poly_reg <= polyn_red_in;
        end else if (mult_last) begin
            if (red_en) begin
                rem <= acc_step;
                k   <= KW'(2 * W - 2);
            end else begin
                out_poly_q <= '0;
            end
        end else if (state == REDUCE) begin
            rem <= rem_step;
            k   <= k - KW'(1);
            if (red_last) begin
                out_poly_q <= rem_step[W-1:0] & mask;
            end
        end
    end
`else
    logic unused_reduce_inputs;

    assign unused_reduce_inputs = ^{red_funct, polyn_grade, polyn_red_in};
    assign mult_to_done         = mult_last;
    assign reduce_to_done       = 1'b0;
    assign busy                 = (state == MULT);
    assign out_poly             = '0;
`endif

    always_comb begin : fsm_next
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = MULT;
`ifdef GF_MUL_SEQ_REDUCE_EN
            MULT: if (mult_last) state_next = red_en ? REDUCE : DONE;
            REDUCE: if (red_last) state_next = DONE;
`else
            MULT: if (mult_last) state_next = DONE;
`endif
            // Accepting straight out of DONE skips IDLE for back-to-back requests.
            DONE: if (out_ready) state_next = in_valid ? MULT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every datapath register is reset so an aborted operation leaves nothing visible.
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            acc        <= '0;
            cnt        <= '0;
            carry_mode <= 1'b0;
            mult_out   <= '0;
        end else begin
            if (accept) begin
                a_sh <= {{W{1'b0}}, a};
                b_sh <= b;
                acc  <= '0;
                cnt  <= CW'(STEPS - 1);
`ifdef GF_MUL_SEQ_REDUCE_EN
                carry_mode <= carry_option && !red_funct;
`else
                carry_mode <= carry_option;
`endif
            end else if (state == MULT) begin
                acc  <= acc_step;
                a_sh <= a_sh << B;
                b_sh <= b_sh >> B;
                cnt  <= cnt - CW'(1);
            end

            // acc is left untouched during REDUCE, so it still holds the raw product.
            if (mult_to_done) begin
                mult_out <= acc_step;
            end else if (reduce_to_done) begin
                mult_out <= acc;
            end
        end
    end

endmodule

// File: tb/tb_gf_mul_seq.sv
// Directed bench for gf_mul_seq at W=8: B=1 instance for the vector table, B=2 instance for
// the two-bit-per-cycle case; expectations follow GF_MUL_SEQ_REDUCE_EN when it is defined.
module tb_gf_mul_seq;

`ifdef GF_MUL_SEQ_REDUCE_EN
    localparam bit RED = 1'b1;
`else
    localparam bit RED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid1, in_valid2;
    logic        carry_option, red_funct, out_ready;
    logic [3:0]  polyn_grade;
    logic [8:0]  polyn_red_in;
    logic [7:0]  a, b;

    logic        in_ready1, out_valid1, busy1;
    logic [15:0] mult_out1;
    logic [7:0]  out_poly1;
    logic        in_ready2, out_valid2, busy2;
    logic [15:0] mult_out2;
    logic [7:0]  out_poly2;

    logic        use2;
    logic        ov;
    logic [15:0] mo;
    logic [7:0]  op;

    int checks   = 0;
    int failures = 0;

    assign ov = use2 ? out_valid2 : out_valid1;
    assign mo = use2 ? mult_out2  : mult_out1;
    assign op = use2 ? out_poly2  : out_poly1;

    always #5 clk = ~clk;

    gf_mul_seq #(.DATA_WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .carry_option(carry_option), .red_funct(red_funct), .polyn_grade(polyn_grade),
        .polyn_red_in(polyn_red_in), .a(a), .b(b), .out_valid(out_valid1),
        .out_ready(out_ready), .mult_out(mult_out1), .out_poly(out_poly1), .busy(busy1)
    );

    gf_mul_seq #(.DATA_WIDTH(8), .BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .carry_option(carry_option), .red_funct(red_funct), .polyn_grade(polyn_grade),
        .polyn_red_in(polyn_red_in), .a(a), .b(b), .out_valid(out_valid2),
        .out_ready(out_ready), .mult_out(mult_out2), .out_poly(out_poly2), .busy(busy2)
    );

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        bit          vc;
        bit          vr;
        logic [3:0]  vm;
        logic [8:0]  vp;
        logic [15:0] em;
        logic [7:0]  ep;
        int          el;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic start_op(input bit sel, input logic [7:0] ia, input logic [7:0] ib,
                            input bit ic, input bit ir, input logic [3:0] im, input logic [8:0] ip);
        @(negedge clk);
        use2         = sel;
        a            = ia;
        b            = ib;
        carry_option = ic;
        red_funct    = ir;
        polyn_grade  = im;
        polyn_red_in = ip;
        if (sel) in_valid2 = 1'b1;
        else     in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        // Scramble inputs after the accept: the operation must not see them.
        a            = ~ia;
        b            = ~ib;
        carry_option = ~ic;
        red_funct    = ~ir;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (ov !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;

        in_valid1 = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1; use2 = 1'b0;
        a = '0; b = '0; carry_option = 1'b0; red_funct = 1'b0;
        polyn_grade = '0; polyn_red_in = '0; rst_n = 1'b1;

        vecs[0] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 4'd0, 9'h000, 16'hFE01, 8'h00, 8};
        vecs[1] = '{8'h57, 8'h83, 1'b0, 1'b1, 4'd8, 9'h11B, 16'h2B79,
                    (RED ? 8'hC1 : 8'h00), (RED ? 15 : 8)};
        vecs[2] = '{8'h57, 8'h83, 1'b1, 1'b0, 4'd0, 9'h000, 16'h2C85, 8'h00, 8};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 4'd0, 9'h000, 16'h5555, 8'h00, 8};
        vecs[4] = '{8'h00, 8'hAB, 1'b1, 1'b0, 4'd0, 9'h000, 16'h0000, 8'h00, 8};
        vecs[5] = '{8'h01, 8'h80, 1'b0, 1'b0, 4'd0, 9'h000, 16'h0080, 8'h00, 8};
        vecs[6] = '{8'h03, 8'h03, 1'b1, 1'b1, 4'd1, 9'h003,
                    (RED ? 16'h0005 : 16'h0009), 8'h00, 8};
        vecs[7] = '{8'h0F, 8'h0F, 1'b0, 1'b1, 4'd4, 9'h013, 16'h0055,
                    (RED ? 8'h0A : 8'h00), (RED ? 19 : 8)};
        vecs[8] = '{8'h57, 8'h83, 1'b1, 1'b1, 4'd9, 9'h000,
                    (RED ? 16'h2B79 : 16'h2C85), 8'h00, 8};
        vecs[9] = '{8'h02, 8'h80, 1'b0, 1'b1, 4'd8, 9'h11B, 16'h0100,
                    (RED ? 8'h1B : 8'h00), (RED ? 15 : 8)};

        // Reset state, asserted before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_mult_out", 32'(mult_out1), 32'h0);
        check("rst_out_poly", 32'(out_poly1), 32'h0);
        check("rst_out_valid", 32'(out_valid1), 32'h0);
        check("rst_busy", 32'(busy1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready1", 32'(in_ready1), 32'h1);
        check("rst_in_ready2", 32'(in_ready2), 32'h1);

        for (int i = 0; i < 10; i++) begin
            start_op(1'b0, vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vr, vecs[i].vm, vecs[i].vp);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].el));
            check($sformatf("v%0d_mult_out", i), 32'(mo), 32'(vecs[i].em));
            check($sformatf("v%0d_out_poly", i), 32'(op), 32'(vecs[i].ep));
        end

        // Two bits per cycle: four MULT cycles.
        start_op(1'b1, 8'h03, 8'h03, 1'b0, 1'b0, 4'd0, 9'h000);
        wait_done(lat);
        check("b2_latency", 32'(lat), 32'd4);
        check("b2_mult_out", 32'(mo), 32'h0005);
        start_op(1'b1, 8'h03, 8'h03, 1'b1, 1'b1, 4'd1, 9'h003);
        wait_done(lat);
        check("b2_m1_latency", 32'(lat), 32'd4);
        check("b2_m1_mult_out", 32'(mo), (RED ? 32'h0005 : 32'h0009));
        check("b2_m1_out_poly", 32'(op), 32'h0);

        // Back-pressure in DONE, then a back-to-back accept.
        out_ready = 1'b0;
        start_op(1'b0, 8'h12, 8'h34, 1'b1, 1'b0, 4'd0, 9'h000);
        wait_done(lat);
        check("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_valid%0d", i), 32'(out_valid1), 32'h1);
            check($sformatf("bp_hold_mult%0d", i), 32'(mult_out1), 32'h03A8);
            check($sformatf("bp_hold_ready%0d", i), 32'(in_ready1), 32'h0);
        end
        @(negedge clk);
        a = 8'h0D; b = 8'h0B; carry_option = 1'b0; red_funct = 1'b0;
        in_valid1 = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready1), 32'h1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check("b2b_busy", 32'(busy1), 32'h1);
        check("b2b_out_valid", 32'(out_valid1), 32'h0);
        wait_done(lat);
        check("b2b_latency", 32'(lat), 32'd8);
        check("b2b_mult_out", 32'(mult_out1), 32'h007F);

        // Reset in the middle of MULT.
        start_op(1'b0, 8'hAA, 8'h55, 1'b1, 1'b0, 4'd0, 9'h000);
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy1), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mult_out", 32'(mult_out1), 32'h0);
        check("mid_rst_out_poly", 32'(out_poly1), 32'h0);
        check("mid_rst_busy", 32'(busy1), 32'h0);
        check("mid_rst_out_valid", 32'(out_valid1), 32'h0);
        #1 rst_n = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready1), 32'h1);
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid1 === 1'b1) pulses++;
        end
        check("mid_rst_no_valid", 32'(pulses), 32'h0);
        start_op(1'b0, 8'h0B, 8'h0D, 1'b1, 1'b0, 4'd0, 9'h000);
        wait_done(lat);
        check("post_rst_latency", 32'(lat), 32'd8);
        check("post_rst_mult_out", 32'(mult_out1), 32'h008F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
